// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit.
//   Takes the EX-stage ALU result as the effective address for loads
//   (opcode 00000) and stores (opcode 01000). It drives a word-wide
//   request/acknowledge data-memory port, forms byte strobes and
//   lane-replicated store data, and extends load data for writeback.
//   While an access is outstanding it stalls the pipeline.
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   valid_in, opcode, func3   EX/MEM instruction valid / class / size+sign
//   addr, store_data, rd_in   effective address, rs2 value, destination reg
//   dm_req/we/addr/wstrb/wdata  memory request (held stable until ack)
//   dm_ack, dm_rdata          memory completion and read word (same cycle)
//   stall                     combinational upstream hold
//   wb_valid, wb_rd, wb_data  one-cycle load writeback
//   misaligned, bus_err       one-cycle fault pulses
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    // Returns {wstrb, wdata} for a store of size func3[1:0] at byte offset lo.
    function automatic logic [35:0] store_fmt(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] sd);
        logic [35:0] r;
        case (f3[1:0])
            2'b00:   r = {4'b0001 << lo, {4{sd[7:0]}}};
            2'b01:   r = {(lo[1] ? 4'b1100 : 4'b0011), {2{sd[15:0]}}};
            2'b10:   r = {4'b1111, sd};
            default: r = {4'b0000, 32'h0000_0000};
        endcase
        return r;
    endfunction

    // Aligns the addressed lane to bit 0, then sign/zero-extends per func3.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3,
                                             input logic [1:0] lo,
                                             input logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] r;
        s = rd >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'h00_0000, s[7:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              is_load_s, is_store_s, legal_s, aligned_s;
    logic              accept_s, timeout_hit_s;
    logic [35:0]       sfmt_s;

    // Decode the incoming instruction: class, legality and alignment.
    always_comb begin
        is_load_s  = valid_in & (opcode == OP_LOAD);
        is_store_s = valid_in & (opcode == OP_STORE);
        case (func3)
            3'b000, 3'b001, 3'b010: legal_s = is_load_s | is_store_s;
            3'b100, 3'b101:         legal_s = is_load_s;
            default:                legal_s = 1'b0;
        endcase
        case (func3[1:0])
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~addr[0];
            2'b10:   aligned_s = (addr[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
    end

    assign accept_s      = (state_q == IDLE) & legal_s & aligned_s;
    // The final BUSY cycle is the one in which the counter would reach the limit.
    assign timeout_hit_s = (state_q == BUSY) & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign sfmt_s        = store_fmt(func3, addr[1:0], store_data);

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_store_s;
                    addr_d  = {addr[31:2], 2'b00};
                    wstrb_d = is_store_s ? sfmt_s[35:32] : 4'b0000;
                    wdata_d = is_store_s ? sfmt_s[31:0]  : 32'h0000_0000;
                    f3_d    = func3;
                    lo_d    = addr[1:0];
                    rd_d    = rd_in;
                end else if (legal_s) begin
                    mis_d = 1'b1;
                end else begin
                    mis_d = 1'b0;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    // Ack has priority over a coincident timeout.
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_fmt(f3_q, lo_q, dm_rdata);
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else if (timeout_hit_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'h0000_0000;
            f3_q       <= 3'b000;
            lo_q       <= 2'b00;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0000_0000;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign dm_req     = req_q;
    assign dm_we      = we_q;
    assign dm_addr    = addr_q;
    assign dm_wstrb   = wstrb_q;
    assign dm_wdata   = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    // Gated by rst so the hold releases immediately when reset asserts.
    assign stall = ~rst & ((accept_s) |
                           ((state_q == BUSY) & ~dm_ack & ~timeout_hit_s));

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
        .func3(func3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .stall(stall), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, expect it to be accepted, then drop valid.
    task automatic start(input string tag, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
        valid_in = 1'b1; opcode = op; func3 = f3; addr = a; store_data = sd; rd_in = rd;
        #1;
        check({tag, "_accept_stall"}, 32'(stall), 32'd1);
        step();
        valid_in = 1'b0;
        check({tag, "_req"}, 32'(dm_req), 32'd1);
    endtask

    // Hold off n BUSY cycles (stall must stay high), then ack on the next one.
    task automatic ack_after(input string tag, input int n, input logic [31:0] rdata);
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_wait_stall"}, 32'(stall), 32'd1);
            check({tag, "_wait_req"}, 32'(dm_req), 32'd1);
            step();
        end
        dm_ack = 1'b1; dm_rdata = rdata;
        #1;
        check({tag, "_ack_stall"}, 32'(stall), 32'd0);
        step();
        dm_ack = 1'b0;
        check({tag, "_req_drop"}, 32'(dm_req), 32'd0);
    endtask

    // Present an instruction that must not start an access.
    task automatic reject(input string tag, input logic [4:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic exp_mis);
        valid_in = 1'b1; opcode = op; func3 = f3; addr = a; rd_in = 5'd3;
        #1;
        check({tag, "_stall"}, 32'(stall), 32'd0);
        step();
        valid_in = 1'b0;
        check({tag, "_mis"}, 32'(misaligned), 32'(exp_mis));
        check({tag, "_req"}, 32'(dm_req), 32'd0);
        check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        step();
        check({tag, "_mis_end"}, 32'(misaligned), 32'd0);
        check({tag, "_req_end"}, 32'(dm_req), 32'd0);
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; opcode = 5'b11111; func3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; rd_in = 5'd0; dm_ack = 1'b0; dm_rdata = 32'h0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_berr", 32'(bus_err), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        rst = 1'b0;
        step();

        // lb at 0x103, two wait cycles, then ack
        start("lb", 5'b00000, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
        check("lb_addr", dm_addr, 32'h0000_0100);
        check("lb_we", 32'(dm_we), 32'd0);
        ack_after("lb", 2, 32'h80FF_1234);
        check("lb_wbv", 32'(wb_valid), 32'd1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_rd", 32'(wb_rd), 32'd5);
        // lbu accepted back-to-back in the first IDLE cycle
        start("lbu", 5'b00000, 3'b100, 32'h0000_0103, 32'h0, 5'd6);
        check("lbu_wbv_gone", 32'(wb_valid), 32'd0);
        ack_after("lbu", 2, 32'h80FF_1234);
        check("lbu_wbv", 32'(wb_valid), 32'd1);
        check("lbu_data", wb_data, 32'h0000_0080);
        check("lbu_rd", 32'(wb_rd), 32'd6);
        step();
        check("lbu_wbv_pulse", 32'(wb_valid), 32'd0);

        // sh at 0x102, immediate ack, lw follows next cycle
        start("sh", 5'b01000, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd7);
        check("sh_we", 32'(dm_we), 32'd1);
        check("sh_strb", 32'(dm_wstrb), 32'hC);
        check("sh_wdata", dm_wdata, 32'hABCD_ABCD);
        check("sh_addr", dm_addr, 32'h0000_0100);
        ack_after("sh", 0, 32'h5555_5555);
        check("sh_no_wbv", 32'(wb_valid), 32'd0);
        start("lw", 5'b00000, 3'b010, 32'h0000_0200, 32'h0, 5'd0);
        check("lw_addr", dm_addr, 32'h0000_0200);
        check("lw_we", 32'(dm_we), 32'd0);
        ack_after("lw", 1, 32'hDEAD_BEEF);
        check("lw_wbv", 32'(wb_valid), 32'd1);
        check("lw_data", wb_data, 32'hDEAD_BEEF);
        check("lw_rd0", 32'(wb_rd), 32'd0);

        // sb at offset 2: byte lane replication and shifted strobe
        start("sb", 5'b01000, 3'b000, 32'h0000_0302, 32'h0000_00A5, 5'd1);
        check("sb_strb", 32'(dm_wstrb), 32'h4);
        check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
        ack_after("sb", 0, 32'h0);
        // lh at offset 2, negative half
        start("lh", 5'b00000, 3'b001, 32'h0000_0302, 32'h0, 5'd9);
        ack_after("lh", 0, 32'h8001_7FFF);
        check("lh_data", wb_data, 32'hFFFF_8001);
        check("lh_wbv", 32'(wb_valid), 32'd1);

        // misaligned accesses
        reject("lw_mis", 5'b00000, 3'b010, 32'h0000_0101, 1'b1);
        reject("lh_mis", 5'b00000, 3'b001, 32'h0000_0003, 1'b1);

        // sw at 0x40 with no ack: 64 BUSY cycles then bus_err
        start("sw_to", 5'b01000, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd2);
        check("sw_to_strb", 32'(dm_wstrb), 32'hF);
        check("sw_to_wdata", dm_wdata, 32'hCAFE_F00D);
        for (int i = 0; i < 63; i++) begin
            #1;
            check("to_stall", 32'(stall), 32'd1);
            check("to_req", 32'(dm_req), 32'd1);
            check("to_berr_early", 32'(bus_err), 32'd0);
            step();
        end
        #1;
        check("to_last_stall", 32'(stall), 32'd0);
        step();
        check("to_berr", 32'(bus_err), 32'd1);
        check("to_req_drop", 32'(dm_req), 32'd0);
        check("to_no_wbv", 32'(wb_valid), 32'd0);
        step();
        check("to_berr_pulse", 32'(bus_err), 32'd0);

        // same store, ack exactly on BUSY cycle 64
        start("sw_ack64", 5'b01000, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd2);
        ack_after("sw_ack64", 63, 32'h0);
        check("ack64_no_berr", 32'(bus_err), 32'd0);
        check("ack64_no_wbv", 32'(wb_valid), 32'd0);

        // reset in the middle of a lw wait
        start("lw_rst", 5'b00000, 3'b010, 32'h0000_0080, 32'h0, 5'd4);
        step();
        #2 rst = 1'b1;
        #1;
        check("mrst_req", 32'(dm_req), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_wbv", 32'(wb_valid), 32'd0);
        step();
        rst = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        step();
        dm_ack = 1'b0;
        check("late_ack_wbv", 32'(wb_valid), 32'd0);
        check("late_ack_req", 32'(dm_req), 32'd0);
        check("late_ack_berr", 32'(bus_err), 32'd0);

        // illegal func3 and non-memory opcode are no-ops
        reject("ld_f3_011", 5'b00000, 3'b011, 32'h0000_0000, 1'b0);
        reject("op_01100", 5'b01100, 3'b010, 32'h0000_0000, 1'b0);
        reject("st_f3_100", 5'b01000, 3'b100, 32'h0000_0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
